mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the MIPS32 pipeline, sitting between the EX/MEM boundary and the write-back stage. It turns load/store requests into data-bus transactions with a valid/ready handshake, stalls the pipeline while a transaction is outstanding, and registers everything write-back consumes. Write-back receives the raw word read from the bus and performs byte extraction and sign extension itself.

## Interface
Parameters:
- `BUS_WIDTH`, 32: data and address width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  an instruction is presented from EX/MEM this cycle.
- `flush`  in  1  discard the current and in-flight instruction (exception or redirect).
- `mem_read_flag_in`, `mem_write_flag_in`, `mem_sign_ext_flag_in`  in  1 each  load, store, and signed-load flags.
- `mem_sel_in`  in  4 (`MEM_SEL_BUS`)  size code; 4'b0001 = byte, 4'b1111 = word.
- `mem_write_data_in`  in  32  store data (rt).
- `result_in`  in  32  ALU result; this is the effective address for memory operations.
- `reg_write_en_in`  in  1; `reg_write_addr_in`  in  5; `current_pc_addr_in`  in  32.
- `stall_out`  out  1  freezes the PC and all upstream stages.
- `ram_en`  out  1  bus request valid.
- `ram_write_en`  out  4  byte write strobes; 0 for reads.
- `ram_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `ram_write_data`  out  32  aligned store data.
- `ram_ready`  in  1  bus completes the request this cycle.
- `ram_read_data_in`  in  32  read word, valid while `ram_ready` is 1.
- To write-back, all registered: `ram_read_data` 32, `mem_read_flag`, `mem_write_flag`, `mem_sign_ext_flag` 1 each, `mem_sel` 4, `result_out` 32, `reg_write_en_out` 1, `reg_write_addr_out` 5, `current_pc_addr_out` 32.

## Operation
- An access is legal when one of these holds:
  - byte size (`mem_sel_in`=0001) at any address;
  - word size (1111) with `addr[1:0]`=00.
- Every other load or store is illegal. It issues no bus request and passes to write-back as a normal instruction in one cycle, with the flags preserved. Write-back then produces 0.
- Store alignment:
  - byte: strobe = `4'b0001 << addr[1:0]`, data = `{4{wdata[7:0]}}`;
  - word: strobe = 1111, data = `wdata`.
- State machine with two states, IDLE and BUSY:
  - IDLE, `valid_in`, legal access, `!flush`: latch the request, assert `stall_out` combinationally, next state BUSY. Write-back registers load a bubble.
  - IDLE, non-memory or illegal instruction (and no flush): write-back registers load the instruction next edge; `stall_out`=0.
  - BUSY: `ram_en`=1 with the latched address, strobes and data, held stable until `ram_ready`. `stall_out` = `!ram_ready`.
  - BUSY and `ram_ready`: load the write-back registers with the latched control and `ram_read_data_in` (0 for stores), then go to IDLE.
- A bubble means `reg_write_en_out`=0, all flags 0, and `mem_sel`=0.
- Flush:
  - In IDLE, no acceptance takes place and a bubble is written.
  - In BUSY, a kill bit is set. The bus transaction still completes, because requests are never abandoned, but on `ram_ready` a bubble is written instead of the instruction.
- `valid_in`=0 writes a bubble.

## Timing
- Reset: state IDLE, kill bit 0, `ram_en`=0, `stall_out`=0, and every output 0. Reset mid-BUSY drops `ram_en` asynchronously; the bus must tolerate this.
- Non-memory latency: 1 cycle.
- Memory latency: 2 cycles plus N, where N is the number of BUSY cycles with `ram_ready` low. The fastest case is 2 cycles (accept cycle, then BUSY with `ram_ready` high).
- `ram_ready` is ignored outside BUSY.
- Only one request is ever outstanding; there is no back-to-back issue. The next instruction is accepted in the IDLE cycle after completion.
- `flush` and `ram_ready` in the same BUSY cycle: a bubble is written and the next state is IDLE.

## Structure
- Widths come from the shared bus definitions header: `DATA_BUS`, `ADDR_BUS`, `REG_ADDR_BUS`, `MEM_SEL_BUS`.
- Add size-code constants `MEM_SEL_BYTE` and `MEM_SEL_WORD` to the same header.
- State encoding is local.
- One sub-module: `mem_store_align`, which is combinational. Address low bits and size go in; strobe, data and legal flag come out.

## Test plan
- Word load at 0x100, `ram_ready` immediate, bus returns 0xDEADBEEF -> `stall_out` high 1 cycle, `ram_addr`=0x100, `ram_write_en`=0, WB `ram_read_data`=0xDEADBEEF with `reg_write_en_out`=1 two cycles after presentation.
- Byte store of 0x5A at 0x203 -> `ram_addr`=0x200, `ram_write_en`=1000, `ram_write_data`=0x5A5A5A5A.
- Word load with `ram_ready` delayed 3 cycles -> `stall_out` high 4 cycles; `ram_en`, address and strobes stable throughout; latency 5.
- ADD result 0x1234 -> WB `result_out`=0x1234 next cycle, `stall_out` never high, `ram_en` never high.
- Flush during BUSY, then `ram_ready` -> transaction completes and WB sees a bubble (`reg_write_en_out`=0). Misaligned word load at 0x102 -> `ram_en` stays 0 and WB receives it in 1 cycle.
- Reset asserted mid-BUSY -> `ram_en`, `stall_out` and all outputs 0 immediately; after release, the next instruction is accepted normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared bus widths, size codes and the write-back control bundle used by
//   the memory-access stage.
//   No ports.
package mem_access_pkg;

  localparam int DATA_BUS     = 32;
  localparam int ADDR_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int MEM_SEL_BUS  = 4;

  localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

  // Everything write-back needs besides the raw read word.
  typedef struct packed {
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_sign_ext;
    logic [MEM_SEL_BUS-1:0]  mem_sel;
    logic [DATA_BUS-1:0]     result;
    logic                    reg_write_en;
    logic [REG_ADDR_BUS-1:0] reg_write_addr;
    logic [ADDR_BUS-1:0]     pc;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
//   Data-bus request/response bundle between the memory-access stage and RAM.
//   ram_en            request valid (master -> slave)
//   ram_write_en[3:0] byte write strobes, 0 for reads
//   ram_addr          word-aligned address
//   ram_write_data    aligned store data
//   ram_ready         slave completes the request this cycle
//   ram_read_data_in  read word, valid with ram_ready
interface mem_access_if;
  import mem_access_pkg::*;

  logic                   ram_en;
  logic [MEM_SEL_BUS-1:0] ram_write_en;
  logic [ADDR_BUS-1:0]    ram_addr;
  logic [DATA_BUS-1:0]    ram_write_data;
  logic                   ram_ready;
  logic [DATA_BUS-1:0]    ram_read_data_in;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ready, ram_read_data_in
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ready, ram_read_data_in
  );

endinterface

// File: rtl/mem_store_align.sv
// mem_store_align
//   Combinational size/alignment check and store-lane steering.
//   i_addr_lo  effective address bits [1:0]
//   i_mem_sel  size code (byte / word)
//   i_wdata    unaligned store data (rt)
//   o_strb     byte write strobes (0 when illegal)
//   o_wdata    store data replicated/steered onto the bus lanes
//   o_legal    size/alignment combination is supported
module mem_store_align
  import mem_access_pkg::*;
(
  input  logic [1:0]             i_addr_lo,
  input  logic [MEM_SEL_BUS-1:0] i_mem_sel,
  input  logic [DATA_BUS-1:0]    i_wdata,
  output logic [MEM_SEL_BUS-1:0] o_strb,
  output logic [DATA_BUS-1:0]    o_wdata,
  output logic                   o_legal
);

  always_comb begin
    o_strb  = '0;
    o_wdata = '0;
    o_legal = 1'b0;
    if (i_mem_sel == MEM_SEL_BYTE) begin
      o_legal = 1'b1;
      o_strb  = 4'b0001 << i_addr_lo;
      o_wdata = {4{i_wdata[7:0]}};
    end else if ((i_mem_sel == MEM_SEL_WORD) && (i_addr_lo == 2'b00)) begin
      o_legal = 1'b1;
      o_strb  = 4'b1111;
      o_wdata = i_wdata;
    end
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   MIPS32 memory-access stage: turns loads/stores into single outstanding
//   bus transactions, stalls upstream while one is in flight, and registers
//   the write-back bundle. Write-back does byte extraction/sign extension.
//   clk, rst (async, active-low)
//   valid_in, flush, mem_*_in, result_in (effective address), reg_write_*_in,
//   current_pc_addr_in                     : from EX/MEM
//   stall_out                              : freeze PC and upstream stages
//   bus (master modport)                   : data bus
//   ram_read_data, mem_*_flag, mem_sel, result_out, reg_write_*_out,
//   current_pc_addr_out                    : registered, to write-back
//
//   state | meaning
//   IDLE  | accepting; non-memory/illegal ops pass straight to write-back
//   BUSY  | request latched and driven on the bus until ram_ready
module mem_access
  import mem_access_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    flush,
  input  logic                    mem_read_flag_in,
  input  logic                    mem_write_flag_in,
  input  logic                    mem_sign_ext_flag_in,
  input  logic [MEM_SEL_BUS-1:0]  mem_sel_in,
  input  logic [DATA_BUS-1:0]     mem_write_data_in,
  input  logic [DATA_BUS-1:0]     result_in,
  input  logic                    reg_write_en_in,
  input  logic [REG_ADDR_BUS-1:0] reg_write_addr_in,
  input  logic [ADDR_BUS-1:0]     current_pc_addr_in,
  output logic                    stall_out,
  mem_access_if.master            bus,
  output logic [DATA_BUS-1:0]     ram_read_data,
  output logic                    mem_read_flag,
  output logic                    mem_write_flag,
  output logic                    mem_sign_ext_flag,
  output logic [MEM_SEL_BUS-1:0]  mem_sel,
  output logic [DATA_BUS-1:0]     result_out,
  output logic                    reg_write_en_out,
  output logic [REG_ADDR_BUS-1:0] reg_write_addr_out,
  output logic [ADDR_BUS-1:0]     current_pc_addr_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_kill;
  logic                    w_kill_nxt;
  logic                    w_accept;

  wb_ctrl_t                w_in_ctrl;
  wb_ctrl_t                r_req_ctrl;
  wb_ctrl_t                w_wb_ctrl;
  logic [DATA_BUS-1:0]     w_wb_rdata;

  logic [BUS_WIDTH-1:0]    r_req_addr;
  logic [MEM_SEL_BUS-1:0]  r_req_strb;
  logic [DATA_BUS-1:0]     r_req_wdata;

  logic [MEM_SEL_BUS-1:0]  w_strb;
  logic [DATA_BUS-1:0]     w_wdata;
  logic                    w_legal;
  logic                    w_is_mem;
  logic                    w_busy;

  mem_store_align u_align (
    .i_addr_lo (result_in[1:0]),
    .i_mem_sel (mem_sel_in),
    .i_wdata   (mem_write_data_in),
    .o_strb    (w_strb),
    .o_wdata   (w_wdata),
    .o_legal   (w_legal)
  );

  assign w_is_mem = mem_read_flag_in | mem_write_flag_in;
  assign w_busy   = (r_state == ST_BUSY);

  always_comb begin
    w_in_ctrl                = '0;
    w_in_ctrl.mem_read       = mem_read_flag_in;
    w_in_ctrl.mem_write      = mem_write_flag_in;
    w_in_ctrl.mem_sign_ext   = mem_sign_ext_flag_in;
    w_in_ctrl.mem_sel        = mem_sel_in;
    w_in_ctrl.result         = result_in;
    w_in_ctrl.reg_write_en   = reg_write_en_in;
    w_in_ctrl.reg_write_addr = reg_write_addr_in;
    w_in_ctrl.pc             = current_pc_addr_in;
  end

  // Write-back gets a bubble unless an instruction retires this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    w_accept    = 1'b0;
    stall_out   = 1'b0;
    w_wb_ctrl   = '0;
    w_wb_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in && !flush) begin
          if (w_is_mem && w_legal) begin
            w_accept    = 1'b1;
            stall_out   = 1'b1;
            w_state_nxt = ST_BUSY;
          end else begin
            // illegal accesses retire with flags intact and read data 0
            w_wb_ctrl = w_in_ctrl;
          end
        end
      end
      ST_BUSY: begin
        if (bus.ram_ready) begin
          w_state_nxt = ST_IDLE;
          w_kill_nxt  = 1'b0;
          if (!(r_kill || flush)) begin
            w_wb_ctrl  = r_req_ctrl;
            w_wb_rdata = r_req_ctrl.mem_read ? bus.ram_read_data_in : '0;
          end
        end else begin
          stall_out = 1'b1;
          // the bus request is never abandoned; only its result is dropped
          if (flush) w_kill_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_ctrl  <= '0;
      r_req_addr  <= '0;
      r_req_strb  <= '0;
      r_req_wdata <= '0;
    end else if (w_accept) begin
      r_req_ctrl  <= w_in_ctrl;
      r_req_addr  <= {result_in[BUS_WIDTH-1:2], 2'b00};
      r_req_strb  <= mem_write_flag_in ? w_strb : '0;
      r_req_wdata <= mem_write_flag_in ? w_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_read_data       <= '0;
      mem_read_flag       <= 1'b0;
      mem_write_flag      <= 1'b0;
      mem_sign_ext_flag   <= 1'b0;
      mem_sel             <= '0;
      result_out          <= '0;
      reg_write_en_out    <= 1'b0;
      reg_write_addr_out  <= '0;
      current_pc_addr_out <= '0;
    end else begin
      ram_read_data       <= w_wb_rdata;
      mem_read_flag       <= w_wb_ctrl.mem_read;
      mem_write_flag      <= w_wb_ctrl.mem_write;
      mem_sign_ext_flag   <= w_wb_ctrl.mem_sign_ext;
      mem_sel             <= w_wb_ctrl.mem_sel;
      result_out          <= w_wb_ctrl.result;
      reg_write_en_out    <= w_wb_ctrl.reg_write_en;
      reg_write_addr_out  <= w_wb_ctrl.reg_write_addr;
      current_pc_addr_out <= w_wb_ctrl.pc;
    end
  end

  assign bus.ram_en         = w_busy;
  assign bus.ram_addr       = w_busy ? r_req_addr : '0;
  assign bus.ram_write_en   = w_busy ? r_req_strb : '0;
  assign bus.ram_write_data = w_busy ? r_req_wdata : '0;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst_b;
  logic        valid_in, flush;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, result_in, current_pc_addr_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic        stall_out;
  logic [31:0] ram_read_data, result_out, current_pc_addr_out;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag, reg_write_en_out;
  logic [3:0]  mem_sel;
  logic [4:0]  reg_write_addr_out;

  mem_access_if bus ();

  mem_access #(.BUS_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst_b),
    .valid_in             (valid_in),
    .flush                (flush),
    .mem_read_flag_in     (mem_read_flag_in),
    .mem_write_flag_in    (mem_write_flag_in),
    .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
    .mem_sel_in           (mem_sel_in),
    .mem_write_data_in    (mem_write_data_in),
    .result_in            (result_in),
    .reg_write_en_in      (reg_write_en_in),
    .reg_write_addr_in    (reg_write_addr_in),
    .current_pc_addr_in   (current_pc_addr_in),
    .stall_out            (stall_out),
    .bus                  (bus),
    .ram_read_data        (ram_read_data),
    .mem_read_flag        (mem_read_flag),
    .mem_write_flag       (mem_write_flag),
    .mem_sign_ext_flag    (mem_sign_ext_flag),
    .mem_sel              (mem_sel),
    .result_out           (result_out),
    .reg_write_en_out     (reg_write_en_out),
    .reg_write_addr_out   (reg_write_addr_out),
    .current_pc_addr_out  (current_pc_addr_out)
  );

  typedef struct {
    logic [31:0] rdata, result, pc;
    logic        rd, wr, sx, we;
    logic [3:0]  sel;
    logic [4:0]  wa;
    int          t0, lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0;
  int          ready_delay = 0, wcnt = 0;
  int          n_stall = 0, n_en = 0;
  logic [31:0] rd_word = '0;
  logic        en_prev = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_strb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // bus slave: completes a request after ready_delay low cycles
  assign bus.ram_read_data_in = rd_word;
  initial bus.ram_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bus.ram_en) begin
      bus.ram_ready = (wcnt >= ready_delay);
      wcnt++;
    end else begin
      bus.ram_ready = 1'b0;
      wcnt = 0;
    end
  end

  // write-back scoreboard and bus stability monitor
  always @(negedge clk) begin
    if (rst_b) begin
      if (stall_out) n_stall++;
      if (bus.ram_en) begin
        n_en++;
        if (!en_prev) begin
          cap_addr  = bus.ram_addr;
          cap_strb  = bus.ram_write_en;
          cap_wdata = bus.ram_write_data;
        end else begin
          chk("bus_addr_stable", bus.ram_addr, cap_addr);
          chk("bus_strb_stable", 32'(bus.ram_write_en), 32'(cap_strb));
          chk("bus_wdata_stable", bus.ram_write_data, cap_wdata);
        end
      end
      en_prev = bus.ram_en;
      if (reg_write_en_out || mem_read_flag || mem_write_flag || mem_sign_ext_flag ||
          (mem_sel != 4'd0)) begin
        if (sb_q.size() == 0) begin
          chk("wb_unexpected_result", result_out, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("wb_latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("wb_rdata", ram_read_data, e.rdata);
          chk("wb_result", result_out, e.result);
          chk("wb_pc", current_pc_addr_out, e.pc);
          chk("wb_flags", {27'd0, mem_read_flag, mem_write_flag, mem_sign_ext_flag, reg_write_en_out, 1'b0},
              {27'd0, e.rd, e.wr, e.sx, e.we, 1'b0});
          chk("wb_sel", 32'(mem_sel), 32'(e.sel));
          chk("wb_waddr", 32'(reg_write_addr_out), 32'(e.wa));
        end
      end
    end else begin
      en_prev = 1'b0;
    end
  end

  task automatic set_ins(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                         input logic [31:0] wd, input logic [31:0] addr, input logic we,
                         input logic [4:0] wa, input logic [31:0] pc);
    mem_read_flag_in     = rd;
    mem_write_flag_in    = wr;
    mem_sign_ext_flag_in = sx;
    mem_sel_in           = sel;
    mem_write_data_in    = wd;
    result_in            = addr;
    reg_write_en_in      = we;
    reg_write_addr_in    = wa;
    current_pc_addr_in   = pc;
  endtask

  // presents the current inputs until accepted; starts and ends at posedge+1
  task automatic drive(input int lat, input logic [31:0] exp_rdata, input bit push);
    exp_t e;
    logic st;
    int   g;
    e.rd = mem_read_flag_in;  e.wr = mem_write_flag_in; e.sx = mem_sign_ext_flag_in;
    e.sel = mem_sel_in;       e.result = result_in;     e.we = reg_write_en_in;
    e.wa = reg_write_addr_in; e.pc = current_pc_addr_in; e.rdata = exp_rdata;
    e.t0 = cyc;               e.lat = lat;
    if (push) sb_q.push_back(e);
    valid_in = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      st = stall_out;
      @(posedge clk);
      #1;
      g++;
    end while (st && g < 50);
    if (st) chk("drive_timeout_cycles", 32'(g), 32'd0);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    valid_in = 1'b0;
    flush = 1'b0;
    set_ins(0, 0, 0, 4'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_reg_we", 32'(reg_write_en_out), 32'd0);
    chk("rst_result", result_out, 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(1);

    // word load, immediate ready
    rd_word = 32'hDEAD_BEEF; ready_delay = 0; n_stall = 0; n_en = 0;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'h1111_1111, 32'h0000_0100, 1, 5'd8, 32'h0040_0010);
    drive(2, 32'hDEAD_BEEF, 1);
    idle(2);
    chk("ldw_stall_cycles", 32'(n_stall), 32'd1);
    chk("ldw_en_cycles", 32'(n_en), 32'd1);
    chk("ldw_addr", cap_addr, 32'h0000_0100);
    chk("ldw_strb", 32'(cap_strb), 32'd0);

    // byte store 0x5A at 0x203
    n_stall = 0; n_en = 0;
    set_ins(0, 1, 0, MEM_SEL_BYTE, 32'h1234_565A, 32'h0000_0203, 0, 5'd0, 32'h0040_0014);
    drive(2, 32'd0, 1);
    idle(2);
    chk("sb_addr", cap_addr, 32'h0000_0200);
    chk("sb_strb", 32'(cap_strb), 32'b1000);
    chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);

    // word store at 0x40C
    set_ins(0, 1, 0, MEM_SEL_WORD, 32'hA1B2_C3D4, 32'h0000_040C, 0, 5'd0, 32'h0040_0018);
    drive(2, 32'd0, 1);
    idle(1);
    chk("sw_addr", cap_addr, 32'h0000_040C);
    chk("sw_strb", 32'(cap_strb), 32'hF);
    chk("sw_wdata", cap_wdata, 32'hA1B2_C3D4);

    // word load with ready delayed 3 cycles, then a back-to-back ADD
    rd_word = 32'h0BAD_F00D; ready_delay = 3; n_stall = 0; n_en = 0;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'd0, 32'h0000_0040, 1, 5'd9, 32'h0040_001C);
    drive(5, 32'h0BAD_F00D, 1);
    set_ins(0, 0, 0, 4'd0, 32'd0, 32'h0000_0077, 1, 5'd4, 32'h0040_0020);
    drive(1, 32'd0, 1);
    idle(2);
    chk("ldw3_stall_cycles", 32'(n_stall), 32'd4);
    chk("ldw3_en_cycles", 32'(n_en), 32'd4);
    chk("ldw3_addr", cap_addr, 32'h0000_0040);

    // ADD 0x1234: no stall, no bus request
    ready_delay = 0; n_stall = 0; n_en = 0;
    set_ins(0, 0, 0, 4'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1, 5'd3, 32'h0040_0024);
    drive(1, 32'd0, 1);
    idle(2);
    chk("add_stall_cycles", 32'(n_stall), 32'd0);
    chk("add_en_cycles", 32'(n_en), 32'd0);

    // signed byte load at 0x101: raw word returned
    rd_word = 32'h80FF_7F01; n_en = 0;
    set_ins(1, 0, 1, MEM_SEL_BYTE, 32'd0, 32'h0000_0101, 1, 5'd10, 32'h0040_0028);
    drive(2, 32'h80FF_7F01, 1);
    idle(1);
    chk("lb_addr", cap_addr, 32'h0000_0100);
    chk("lb_strb", 32'(cap_strb), 32'd0);

    // misaligned word load at 0x102: illegal, 1 cycle, no request
    rd_word = 32'hCAFE_F00D; n_stall = 0; n_en = 0;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'd0, 32'h0000_0102, 1, 5'd11, 32'h0040_002C);
    drive(1, 32'd0, 1);
    // misaligned word store at 0x206
    set_ins(0, 1, 0, MEM_SEL_WORD, 32'h1357_9BDF, 32'h0000_0206, 0, 5'd0, 32'h0040_0030);
    drive(1, 32'd0, 1);
    idle(2);
    chk("mis_en_cycles", 32'(n_en), 32'd0);
    chk("mis_stall_cycles", 32'(n_stall), 32'd0);

    // flush during BUSY: transaction completes, result dropped
    rd_word = 32'h7777_7777; ready_delay = 2; n_en = 0;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'd0, 32'h0000_0300, 1, 5'd12, 32'h0040_0034);
    valid_in = 1'b1;
    idle(1);
    chk("flb_accepted", 32'(bus.ram_en), 32'd1);
    flush = 1'b1;
    valid_in = 1'b0;
    idle(1);
    flush = 1'b0;
    begin
      int g = 0;
      while (bus.ram_en && g < 20) begin
        idle(1);
        g++;
      end
      chk("flb_wait_cycles_ok", 32'(g < 20), 32'd1);
    end
    @(negedge clk);
    chk("flb_bubble_we", 32'(reg_write_en_out), 32'd0);
    chk("flb_bubble_rd", 32'(mem_read_flag), 32'd0);
    chk("flb_en_cycles", 32'(n_en), 32'd3);
    idle(1);

    // flush and ready in the same BUSY cycle, then immediate next instruction
    ready_delay = 0;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'd0, 32'h0000_0310, 1, 5'd13, 32'h0040_0038);
    valid_in = 1'b1;
    idle(1);
    chk("flr_accepted", 32'(bus.ram_en), 32'd1);
    flush = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("flr_stall", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flr_idle", 32'(bus.ram_en), 32'd0);
    chk("flr_bubble_we", 32'(reg_write_en_out), 32'd0);
    @(posedge clk);
    #1;
    set_ins(0, 0, 0, 4'd0, 32'd0, 32'h0000_5555, 1, 5'd14, 32'h0040_003C);
    drive(1, 32'd0, 1);

    // flush in IDLE with an ADD: bubble
    set_ins(0, 0, 0, 4'd0, 32'd0, 32'h0000_6666, 1, 5'd15, 32'h0040_0040);
    valid_in = 1'b1;
    flush = 1'b1;
    idle(1);
    valid_in = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fli_bubble_we", 32'(reg_write_en_out), 32'd0);
    chk("fli_bubble_result", result_out, 32'd0);
    idle(1);

    // reset mid-BUSY
    ready_delay = 8;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'd0, 32'h0000_0180, 1, 5'd16, 32'h0040_0044);
    valid_in = 1'b1;
    idle(1);
    chk("rsb_accepted", 32'(bus.ram_en), 32'd1);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    chk("rsb_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rsb_stall", 32'(stall_out), 32'd0);
    chk("rsb_ram_addr", bus.ram_addr, 32'd0);
    chk("rsb_reg_we", 32'(reg_write_en_out), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(1);
    ready_delay = 0;
    rd_word = 32'h2468_ACE0;
    set_ins(1, 0, 0, MEM_SEL_WORD, 32'd0, 32'h0000_0500, 1, 5'd17, 32'h0040_0048);
    drive(2, 32'h2468_ACE0, 1);
    idle(3);
    chk("rsb_after_addr", cap_addr, 32'h0000_0500);

    chk("sb_remaining", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
